// File: rtl/jt6295_pkg.sv
// ----------------------------------------------------------------------------
// jt6295_pkg
// Shared definitions for the jt6295 phrase-header fetch controller:
//   - header layout constants (bytes per header, phrase table stride)
//   - channel index width
//   - FSM state encoding (plain localparams so older code can compare
//     against them directly)
//   - hdr_addr(): ROM byte address of header byte k of a phrase
// ----------------------------------------------------------------------------
package jt6295_pkg;

    localparam int HDR_BYTES  = 6;
    localparam int TBL_STRIDE = 8;
    localparam int CH_W       = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic [17:0] hdr_addr(input logic [17:0] base,
                                             input logic [6:0]  phrase,
                                             input logic [2:0]  k);
        return base + 18'(phrase) * 18'(TBL_STRIDE) + 18'(k);
    endfunction

endpackage

// File: rtl/jt6295_rr_pick.sv
// ----------------------------------------------------------------------------
// jt6295_rr_pick
// Combinational 4-way round-robin selector. Returns the first set bit of
// pend, searching upward from ptr and wrapping 3 -> 0.
// Ports:
//   pend  in  4  request bits
//   ptr   in  2  search start position
//   sel   out 2  selected index (meaningful only when any=1)
//   any   out 1  at least one request bit set
// ----------------------------------------------------------------------------
module jt6295_rr_pick
    import jt6295_pkg::*;
(
    input  logic [3:0]      pend,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] sel,
    output logic            any
);

    logic [CH_W-1:0] idx;

    // NOTE: every output and temporary gets a default before any branch, so
    // no path leaves them unassigned and no latch is inferred.
    always_comb begin
        sel = ptr;
        idx = ptr;
        any = |pend;
        // Walk from the farthest offset back to the nearest so the nearest
        // set bit is the one that sticks.
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + CH_W'(i);
            if (pend[idx]) sel = idx;
        end
    end

endmodule

// File: rtl/jt6295_hdr_fetch.sv
// ----------------------------------------------------------------------------
// jt6295_hdr_fetch
// Phrase-header fetch controller for the 4-channel ADPCM core. CPU play
// commands queue one request per channel; requests are served round-robin
// through a single ROM slot, reading the 6-byte big-endian header of the
// phrase and delivering start/stop addresses with a one-cycle hdr_valid.
//
// Optional feature macro: JT6295_HDR_CHECK_EN
//   defined   : headers with stop < start or start == 0 are dropped and
//               hdr_err pulses instead of hdr_valid
//   undefined : every header is delivered as read, hdr_err is constant 0
//
// Ports:
//   rst        in  1   asynchronous reset, active-high
//   clk        in  1   clock
//   cmd_we     in  1   play command strobe
//   cmd_phrase in  7   phrase number (0 ignored)
//   cmd_mask   in  4   channel select mask
//   pending    out 4   per-channel request outstanding
//   busy       out 1   fetch in progress (FETCH or DONE)
//   rom_cs     out 1   ROM slot request, held for the whole fetch
//   rom_addr   out 18  ROM byte address
//   rom_data   in  8   ROM byte
//   rom_ok     in  1   slot data valid
//   hdr_valid  out 1   header delivered (one cycle)
//   hdr_ch     out 2   channel of the header
//   hdr_start  out 18  phrase start byte address
//   hdr_stop   out 18  phrase stop byte address
//   hdr_err    out 1   rejected header (one cycle)
// ----------------------------------------------------------------------------
module jt6295_hdr_fetch
    import jt6295_pkg::*;
#(
    parameter int          CH       = 4,
    parameter logic [17:0] TBL_BASE = 18'h0
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            cmd_we,
    input  logic [6:0]      cmd_phrase,
    input  logic [CH-1:0]   cmd_mask,
    output logic [CH-1:0]   pending,
    output logic            busy,
    output logic            rom_cs,
    output logic [17:0]     rom_addr,
    input  logic [7:0]      rom_data,
    input  logic            rom_ok,
    output logic            hdr_valid,
    output logic [CH_W-1:0] hdr_ch,
    output logic [17:0]     hdr_start,
    output logic [17:0]     hdr_stop,
    output logic            hdr_err
);

    logic [1:0]           state_q,     state_d;
    logic [CH-1:0]        pending_q,   pending_d;
    logic [CH-1:0][6:0]   phr_q,       phr_d;
    logic [CH_W-1:0]      ptr_q,       ptr_d;
    logic [CH_W-1:0]      ch_q,        ch_d;
    logic [6:0]           cur_phr_q,   cur_phr_d;
    logic [2:0]           k_q,         k_d;
    logic                 settle_q,    settle_d;
    logic [4:0][7:0]      bytes_q,     bytes_d;
    logic                 rom_cs_q,    rom_cs_d;
    logic [17:0]          rom_addr_q,  rom_addr_d;
    logic                 hdr_valid_q, hdr_valid_d;
    logic                 hdr_err_q,   hdr_err_d;
    logic [CH_W-1:0]      hdr_ch_q,    hdr_ch_d;
    logic [17:0]          hdr_start_q, hdr_start_d;
    logic [17:0]          hdr_stop_q,  hdr_stop_d;

    logic [CH_W-1:0]      pick_sel;
    logic                 pick_any;
    logic [17:0]          asm_start;
    logic [17:0]          asm_stop;
    logic                 hdr_bad;

    jt6295_rr_pick u_pick (
        .pend (pending_q),
        .ptr  (ptr_q),
        .sel  (pick_sel),
        .any  (pick_any)
    );

    // Assembly happens on the cycle byte 5 is accepted, so the last byte
    // comes straight from the bus. Upper 6 bits of b0/b3 are not address.
    assign asm_start = {bytes_q[0][1:0], bytes_q[1], bytes_q[2]};
    assign asm_stop  = {bytes_q[3][1:0], bytes_q[4], rom_data};

`ifdef JT6295_HDR_CHECK_EN
    assign hdr_bad = (asm_stop < asm_start) || (asm_start == 18'h0);
`else
    assign hdr_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        phr_d       = phr_q;
        ptr_d       = ptr_q;
        ch_d        = ch_q;
        cur_phr_d   = cur_phr_q;
        k_d         = k_q;
        settle_d    = settle_q;
        bytes_d     = bytes_q;
        rom_cs_d    = rom_cs_q;
        rom_addr_d  = rom_addr_q;
        hdr_valid_d = 1'b0;
        hdr_err_d   = 1'b0;
        hdr_ch_d    = hdr_ch_q;
        hdr_start_d = hdr_start_q;
        hdr_stop_d  = hdr_stop_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    ch_d                = pick_sel;
                    cur_phr_d           = phr_q[pick_sel];
                    pending_d[pick_sel] = 1'b0;
                    ptr_d               = pick_sel + 2'd1;
                    k_d                 = 3'd0;
                    settle_d            = 1'b0;
                    rom_cs_d            = 1'b1;
                    rom_addr_d          = hdr_addr(TBL_BASE, phr_q[pick_sel], 3'd0);
                    state_d             = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // The slot's ok is registered and still reflects the old
                // address on the first cycle after a change; ignore it then.
                if (!settle_q) begin
                    settle_d = 1'b1;
                end else if (rom_ok) begin
                    if (k_q == 3'(HDR_BYTES - 1)) begin
                        state_d  = ST_DONE;
                        rom_cs_d = 1'b0;
                        hdr_ch_d = ch_q;
                        if (hdr_bad) begin
                            hdr_err_d = 1'b1;
                        end else begin
                            hdr_valid_d = 1'b1;
                            hdr_start_d = asm_start;
                            hdr_stop_d  = asm_stop;
                        end
                    end else begin
                        bytes_d[k_q] = rom_data;
                        k_d          = k_q + 3'd1;
                        settle_d     = 1'b0;
                        rom_addr_d   = hdr_addr(TBL_BASE, cur_phr_q, k_q + 3'd1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Applied after arbitration so a command hitting the channel being
        // picked re-arms it; the fetch already took the older phrase.
        if (cmd_we && (cmd_phrase != 7'd0)) begin
            for (int i = 0; i < CH; i++) begin
                if (cmd_mask[i]) begin
                    pending_d[i] = 1'b1;
                    phr_d[i]     = cmd_phrase;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            // NOTE: the per-channel phrase registers are few and cheap, so
            // they are reset too; a channel is never read before its pending
            // bit is set, but a known value keeps the debug view clean.
            phr_q       <= '0;
            ptr_q       <= '0;
            ch_q        <= '0;
            cur_phr_q   <= '0;
            k_q         <= '0;
            settle_q    <= 1'b0;
            bytes_q     <= '0;
            rom_cs_q    <= 1'b0;
            rom_addr_q  <= '0;
            hdr_valid_q <= 1'b0;
            hdr_err_q   <= 1'b0;
            hdr_ch_q    <= '0;
            hdr_start_q <= '0;
            hdr_stop_q  <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            phr_q       <= phr_d;
            ptr_q       <= ptr_d;
            ch_q        <= ch_d;
            cur_phr_q   <= cur_phr_d;
            k_q         <= k_d;
            settle_q    <= settle_d;
            bytes_q     <= bytes_d;
            rom_cs_q    <= rom_cs_d;
            rom_addr_q  <= rom_addr_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_err_q   <= hdr_err_d;
            hdr_ch_q    <= hdr_ch_d;
            hdr_start_q <= hdr_start_d;
            hdr_stop_q  <= hdr_stop_d;
        end
    end

    assign pending   = pending_q;
    assign busy      = (state_q != ST_IDLE);
    assign rom_cs    = rom_cs_q;
    assign rom_addr  = rom_addr_q;
    assign hdr_valid = hdr_valid_q;
    assign hdr_err   = hdr_err_q;
    assign hdr_ch    = hdr_ch_q;
    assign hdr_start = hdr_start_q;
    assign hdr_stop  = hdr_stop_q;

endmodule

// File: tb/tb_jt6295_hdr_fetch.sv
// ----------------------------------------------------------------------------
// tb_jt6295_hdr_fetch
// Directed plus randomized stimulus for jt6295_hdr_fetch. A transaction-level
// reference model (per-channel pending set, rotating pointer, expected
// delivery queue, phrase table of start/stop values) is advanced once per
// cycle on the falling edge and compared with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_jt6295_hdr_fetch;

    logic        rst;
    logic        clk;
    logic        cmd_we;
    logic [6:0]  cmd_phrase;
    logic [3:0]  cmd_mask;
    logic [3:0]  pending;
    logic        busy;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        hdr_valid;
    logic [1:0]  hdr_ch;
    logic [17:0] hdr_start;
    logic [17:0] hdr_stop;
    logic        hdr_err;

    int checks   = 0;
    int failures = 0;

    // Phrase table contents, stored as the values the header encodes.
    logic [17:0] start_tab [128];
    logic [17:0] stop_tab  [128];
    logic [7:0]  rom_mem   [1024];

    logic fast_ok = 1'b1;
    logic stall   = 1'b0;

    // Reference model state.
    logic [3:0]  pend_m;
    logic [6:0]  phr_m [4];
    int          ptr_m;
    logic        busy_m;
    logic [6:0]  cur_m;
    logic [1:0]  last_ch_m;
    logic [17:0] last_start_m;
    logic [17:0] last_stop_m;
    int          exp_ch_q  [$];
    int          exp_phr_q [$];

    // Delivery log for the directed order checks.
    int          dlv_ch    [$];
    logic [17:0] dlv_start [$];
    int          err_cnt = 0;

    jt6295_hdr_fetch dut (
        .rst        (rst),
        .clk        (clk),
        .cmd_we     (cmd_we),
        .cmd_phrase (cmd_phrase),
        .cmd_mask   (cmd_mask),
        .pending    (pending),
        .busy       (busy),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .hdr_valid  (hdr_valid),
        .hdr_ch     (hdr_ch),
        .hdr_start  (hdr_start),
        .hdr_stop   (hdr_stop),
        .hdr_err    (hdr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_data = (rom_addr[17:10] == 8'h0) ? rom_mem[rom_addr[9:0]] : 8'h00;

    // Slot ok: always high when fast, random otherwise, forced low on stall.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            rom_ok = !stall && (fast_ok || ($urandom_range(0, 2) != 0));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_bad(input int p);
`ifdef JT6295_HDR_CHECK_EN
        return (stop_tab[p] < start_tab[p]) || (start_tab[p] == 18'h0);
`else
        return 1'b0;
`endif
    endfunction

    // One model step per cycle, evaluated mid-cycle when inputs and
    // outputs are both stable.
    task automatic model_step();
        logic nxt_busy;
        int   c;
        int   p;
        if (rst) begin
            pend_m       = '0;
            ptr_m        = 0;
            busy_m       = 1'b0;
            last_ch_m    = '0;
            last_start_m = '0;
            last_stop_m  = '0;
            exp_ch_q.delete();
            exp_phr_q.delete();
            check("rst_pending", pending, 0);
            check("rst_rom_cs", rom_cs, 0);
            return;
        end
        check("pending", pending, pend_m);
        check("busy", busy, busy_m);
        nxt_busy = busy_m;
        if (hdr_valid || hdr_err) begin
            if (exp_ch_q.size() == 0) begin
                check("unexpected_hdr", 1, 0);
            end else begin
                c = exp_ch_q.pop_front();
                p = exp_phr_q.pop_front();
                check("hdr_ch", hdr_ch, c);
                last_ch_m = 2'(c);
                if (is_bad(p)) begin
                    check("bad_valid", hdr_valid, 0);
                    check("bad_err", hdr_err, 1);
                    err_cnt++;
                end else begin
                    check("hdr_valid", hdr_valid, 1);
                    check("hdr_err", hdr_err, 0);
                    check("hdr_start", hdr_start, start_tab[p]);
                    check("hdr_stop", hdr_stop, stop_tab[p]);
                    last_start_m = start_tab[p];
                    last_stop_m  = stop_tab[p];
                    dlv_ch.push_back(c);
                    dlv_start.push_back(hdr_start);
                end
            end
            nxt_busy = 1'b0;
        end else begin
            check("hold_start", hdr_start, last_start_m);
            check("hold_stop", hdr_stop, last_stop_m);
            check("hold_ch", hdr_ch, last_ch_m);
            check("rom_cs", rom_cs, busy_m);
            if (busy_m) begin
                check("rom_entry", rom_addr[17:3], cur_m);
                check("rom_offset_ok", rom_addr[2:0] < 3'd6, 1);
            end
        end
        if (!busy_m && (pend_m != 0)) begin
            for (int off = 0; off < 4; off++) begin
                c = (ptr_m + off) % 4;
                if (pend_m[c] && !nxt_busy) begin
                    nxt_busy  = 1'b1;
                    cur_m     = phr_m[c];
                    pend_m[c] = 1'b0;
                    ptr_m     = (c + 1) % 4;
                    exp_ch_q.push_back(c);
                    exp_phr_q.push_back(int'(phr_m[c]));
                end
            end
        end
        if (cmd_we && cmd_phrase != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (cmd_mask[i]) begin
                    pend_m[i] = 1'b1;
                    phr_m[i]  = cmd_phrase;
                end
            end
        end
        busy_m = nxt_busy;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic do_cmd(input logic [6:0] p, input logic [3:0] m);
        cmd_we     = 1'b1;
        cmd_phrase = p;
        cmd_mask   = m;
        @(posedge clk);
        #1;
        cmd_we     = 1'b0;
        cmd_phrase = '0;
        cmd_mask   = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || pending != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, n < 3000, 1);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_order(input string tag, input int n,
                               input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        check({tag, "_count"}, dlv_ch.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < dlv_ch.size()) check(tag, dlv_ch[i], e[i]);
        end
    endtask

    initial begin
        int          n;
        logic [5:0]  hi_a;
        logic [5:0]  hi_b;
        logic [17:0] s;
        logic [17:0] t;
        logic [17:0] a;

        rst        = 1'b1;
        cmd_we     = 1'b0;
        cmd_phrase = '0;
        cmd_mask   = '0;
        rom_ok     = 1'b0;

        for (int p = 0; p < 128; p++) begin
            s = 18'($urandom);
            t = 18'($urandom);
            if (p >= 4 && p <= 9) begin
                s = 18'($urandom_range(1, 18'h1FFFF));
                t = s + 18'($urandom_range(0, 18'h1FFFF));
            end
            if (p == 3)  begin s = 18'h01000; t = 18'h01234; end
            if (p == 10) begin s = 18'h00200; t = 18'h00100; end
            if (p == 11) begin s = 18'h00000; t = 18'h00050; end
            hi_a = (p == 3) ? 6'd0 : 6'($urandom);
            hi_b = (p == 3) ? 6'd0 : 6'($urandom);
            start_tab[p]     = s;
            stop_tab[p]      = t;
            rom_mem[p*8 + 0] = {hi_a, s[17:16]};
            rom_mem[p*8 + 1] = s[15:8];
            rom_mem[p*8 + 2] = s[7:0];
            rom_mem[p*8 + 3] = {hi_b, t[17:16]};
            rom_mem[p*8 + 4] = t[15:8];
            rom_mem[p*8 + 5] = t[7:0];
            rom_mem[p*8 + 6] = 8'($urandom);
            rom_mem[p*8 + 7] = 8'($urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_pending", pending, 0);
        check("reset_busy", busy, 0);
        check("reset_rom_cs", rom_cs, 0);
        check("reset_rom_addr", rom_addr, 0);
        check("reset_hdr_valid", hdr_valid, 0);
        check("reset_hdr_ch", hdr_ch, 0);
        check("reset_hdr_start", hdr_start, 0);
        check("reset_hdr_stop", hdr_stop, 0);
        check("reset_hdr_err", hdr_err, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single fetch of entry 3 with an always-ready slot.
        do_cmd(7'd3, 4'b0001);
        n = 1;
        while (!hdr_valid && !hdr_err && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n >= 2 && n <= 13) check("single_addr", rom_addr, 18'h18 + 18'((n - 2) / 2));
        end
        check("single_latency", n, 14);
        check("single_ch", hdr_ch, 0);
        check("single_start", hdr_start, 18'h01000);
        check("single_stop", hdr_stop, 18'h01234);
        wait_idle("single_idle");
        check("single_pending", pending, 0);

        // All four channels from a fresh pointer, then two.
        reset_dut();
        dlv_ch.delete();
        do_cmd(7'd5, 4'b1111);
        wait_idle("multi4_idle");
        check_order("multi4_order", 4, 0, 1, 2, 3);
        dlv_ch.delete();
        do_cmd(7'd5, 4'b0011);
        wait_idle("multi2_idle");
        check_order("multi2_order", 2, 0, 1, 0, 0);

        // After ch2 is served, ch3 comes before ch0.
        do_cmd(7'd6, 4'b0100);
        wait_idle("rr_ch2_idle");
        dlv_ch.delete();
        do_cmd(7'd6, 4'b1001);
        wait_idle("rr_idle");
        check_order("rr_order", 2, 3, 0, 0, 0);

        // Overwrite during a fetch of the same channel.
        dlv_ch.delete();
        dlv_start.delete();
        do_cmd(7'd4, 4'b0010);
        repeat (3) @(posedge clk);
        #1;
        check("ovr_busy", busy, 1);
        do_cmd(7'd7, 4'b0010);
        wait_idle("ovr_idle");
        check_order("ovr_order", 2, 1, 1, 0, 0);
        if (dlv_start.size() == 2) begin
            check("ovr_first", dlv_start[0], start_tab[4]);
            check("ovr_second", dlv_start[1], start_tab[7]);
        end else begin
            check("ovr_deliveries", dlv_start.size(), 2);
        end
        do_cmd(7'd0, 4'b0010);
        repeat (5) @(posedge clk);
        #1;
        check("phr0_pending", pending, 0);
        check("phr0_busy", busy, 0);

        // Slot stalls on byte 3 for 20 cycles.
        dlv_start.delete();
        do_cmd(7'd9, 4'b0001);
        n = 0;
        while (!(rom_cs && rom_addr[2:0] == 3'd3) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("slow_reach_b3", n < 100, 1);
        stall = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            check("slow_addr_hold", rom_addr, 18'(9 * 8 + 3));
        end
        stall = 1'b0;
        wait_idle("slow_idle");
        check("slow_deliveries", dlv_start.size(), 1);
        if (dlv_start.size() == 1) check("slow_start", dlv_start[0], start_tab[9]);

        // Reset in the middle of a fetch.
        dlv_ch.delete();
        do_cmd(7'd6, 4'b1111);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_rom_cs", rom_cs, 0);
        check("midrst_pending", pending, 0);
        check("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        check("midrst_rom_cs_edge", rom_cs, 0);
        check("midrst_pending_edge", pending, 0);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("midrst_no_hdr", dlv_ch.size(), 0);
        check("midrst_idle", busy, 0);

        // Inconsistent headers: rejected only when the check is built in.
        dlv_ch.delete();
        n = err_cnt;
        do_cmd(7'd10, 4'b0001);
        wait_idle("bad1_idle");
        do_cmd(7'd11, 4'b0010);
        wait_idle("bad2_idle");
`ifdef JT6295_HDR_CHECK_EN
        check("bad_errs", err_cnt - n, 2);
        check("bad_delivered", dlv_ch.size(), 0);
`else
        check("bad_errs", err_cnt - n, 0);
        check("bad_delivered", dlv_ch.size(), 2);
`endif

        // Random commands with a random-latency slot.
        fast_ok = 1'b0;
        repeat (40) begin
            do_cmd(7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
        end
        wait_idle("rand_idle");
        repeat (3) @(posedge clk);
        #1;
        check("rand_drained", exp_ch_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
